// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data-memory and mainMem signals around mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [1:0]        if_size;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // data-memory requester
    logic              dm_req;
    logic [ADDR_W-1:0] dm_addr;
    logic              dm_wr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;

    // mainMem port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [1:0]        mem_acc_size;
    logic              mem_enable;
    logic              mem_busy;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  if_req, if_addr, if_size,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_addr, dm_wr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata, dm_done,
        output mem_addr, mem_wdata, mem_wren, mem_acc_size, mem_enable,
        input  mem_busy, mem_rdata
    );

    // requesters and memory side
    modport master (
        output if_req, if_addr, if_size,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_addr, dm_wr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata, dm_done,
        input  mem_addr, mem_wdata, mem_wren, mem_acc_size, mem_enable,
        output mem_busy, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single mainMem port between instruction fetch (bursts) and the
// load/store stage (single words); fetch gets forced priority after MAX_WAIT losses.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic               clock,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned BEAT_W = 5;
    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic {IDLE, ISSUE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

    state_t            state;
    owner_t            owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic [BEAT_W-1:0] beats_q;
    logic [WAIT_W-1:0] wait_q;
    logic              enable_q;
    logic              if_gnt_q;
    logic              dm_gnt_q;
    logic              if_rvalid_q;
    logic              dm_rvalid_q;
    logic              dm_done_q;

    logic              force_fetch_c;
    logic              beat_issue_c;
    logic [BEAT_W-1:0] burst_len_c;

    // Arbitration inputs and burst length decode
    always_comb begin
        force_fetch_c = bus.if_req && (wait_q == WAIT_LIMIT);
        beat_issue_c  = (state == ISSUE) && !bus.mem_busy;
        burst_len_c   = BEAT_W'(1);
        case (bus.if_size)
            2'b00:   burst_len_c = BEAT_W'(1);
            2'b01:   burst_len_c = BEAT_W'(4);
            2'b10:   burst_len_c = BEAT_W'(8);
            default: burst_len_c = BEAT_W'(16);
        endcase
    end

    // Grant/issue FSM with registered memory-side and return outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            beats_q     <= '0;
            wait_q      <= '0;
            enable_q    <= 1'b0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            dm_done_q   <= 1'b0;
        end else begin
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            // return path follows the issued beat regardless of state
            if_rvalid_q <= beat_issue_c && (owner == OWN_FETCH);
            dm_rvalid_q <= beat_issue_c && (owner == OWN_DATA) && !wr_q;
            dm_done_q   <= beat_issue_c && (owner == OWN_DATA) && wr_q;

            case (state)
                IDLE: begin
                    if (force_fetch_c || (bus.if_req && !bus.dm_req)) begin
                        state    <= ISSUE;
                        enable_q <= 1'b1;
                        if_gnt_q <= 1'b1;
                        owner    <= OWN_FETCH;
                        addr_q   <= bus.if_addr;
                        beats_q  <= burst_len_c;
                        wr_q     <= 1'b0;
                        wdata_q  <= '0;
                        wait_q   <= '0;
                    end else if (bus.dm_req) begin
                        state    <= ISSUE;
                        enable_q <= 1'b1;
                        dm_gnt_q <= 1'b1;
                        owner    <= OWN_DATA;
                        addr_q   <= bus.dm_addr;
                        beats_q  <= BEAT_W'(1);
                        wr_q     <= bus.dm_wr;
                        wdata_q  <= bus.dm_wdata;
                        if (bus.if_req && (wait_q != WAIT_LIMIT)) begin
                            wait_q <= wait_q + WAIT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (!bus.mem_busy) begin
                        addr_q  <= addr_q + ADDR_W'(4);
                        beats_q <= beats_q - BEAT_W'(1);
                        if (beats_q == BEAT_W'(1)) begin
                            state    <= IDLE;
                            enable_q <= 1'b0;
                            wr_q     <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output drive; read data is the memory word qualified by the owner's valid
    assign bus.if_gnt       = if_gnt_q;
    assign bus.dm_gnt       = dm_gnt_q;
    assign bus.if_rvalid    = if_rvalid_q;
    assign bus.dm_rvalid    = dm_rvalid_q;
    assign bus.dm_done      = dm_done_q;
    assign bus.if_rdata     = if_rvalid_q ? bus.mem_rdata : '0;
    assign bus.dm_rdata     = dm_rvalid_q ? bus.mem_rdata : '0;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_wren     = wr_q;
    assign bus.mem_enable   = enable_q;
    assign bus.mem_acc_size = 2'b00;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter with a mainMem model and return scoreboard.
module tb_mem_port_arbiter;
    logic clk;
    logic reset_n;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        is_fetch;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [31:0] wdata;
        int          busy_after;
        int          busy_len;
        int          exp_cycles;
    } vec_t;

    typedef struct packed {
        logic        done;
        logic [31:0] data;
    } dm_exp_t;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_addr [$];
    logic [31:0] exp_if   [$];
    dm_exp_t     exp_dm   [$];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] mm       [logic [31:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic int burst_beats(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    // mainMem model: synchronous access, read word visible the cycle after issue
    always @(posedge clk) begin
        if (bus.mem_enable && !bus.mem_busy) begin
            if (bus.mem_wren) mm[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata <= mm.exists(bus.mem_addr) ? mm[bus.mem_addr]
                                                           : (bus.mem_addr ^ 32'h5A5A_5A5A);
        end
    end

    // Return monitor: pops expected read data / store completions
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.if_rvalid) begin
                if (exp_if.size() == 0) check("if_rvalid_unexpected", 64'(1), 64'(0));
                else check("if_rdata", 64'(bus.if_rdata), 64'(exp_if.pop_front()));
            end
            if (bus.dm_rvalid || bus.dm_done) begin
                if (exp_dm.size() == 0) check("dm_return_unexpected", 64'(1), 64'(0));
                else begin
                    dm_exp_t e;
                    e = exp_dm.pop_front();
                    check("dm_done", 64'(bus.dm_done), 64'(e.done));
                    check("dm_rvalid", 64'(bus.dm_rvalid), 64'(!e.done));
                    if (!e.done) check("dm_rdata", 64'(bus.dm_rdata), 64'(e.data));
                end
            end
        end
    end

    // One request: push expectations, await grant, drive busy, check addresses and occupancy
    task automatic run_txn(input vec_t v);
        int  beats, lat, cyc, issued, stall, guard;
        bit  got, used;
        logic [31:0] a;
        beats = v.is_fetch ? burst_beats(v.size) : 1;
        @(posedge clk); #1;
        for (int k = 0; k < beats; k++) begin
            a = v.addr + 32'(4 * k);
            exp_addr.push_back(a);
            if (v.is_fetch) exp_if.push_back(ref_word(a));
            else if (v.wr) begin
                exp_dm.push_back('{done: 1'b1, data: 32'h0});
                ref_mem[a] = v.wdata;
            end else exp_dm.push_back('{done: 1'b0, data: ref_word(a)});
        end
        if (v.is_fetch) begin
            bus.if_addr = v.addr; bus.if_size = v.size; bus.if_req = 1'b1;
        end else begin
            bus.dm_addr = v.addr; bus.dm_wr = v.wr; bus.dm_wdata = v.wdata; bus.dm_req = 1'b1;
        end
        lat = 0; got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            got = v.is_fetch ? bus.if_gnt : bus.dm_gnt;
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        check("gnt_latency", 64'(lat), 64'(2));
        if (!got) begin
            exp_addr.delete();
            return;
        end
        cyc = 0; issued = 0; stall = 0; used = 1'b0; guard = 0;
        while (bus.mem_enable && guard < 100) begin
            if (!used && v.busy_len > 0 && issued == v.busy_after + 1) begin
                stall = v.busy_len;
                used  = 1'b1;
            end
            if (stall > 0) begin
                bus.mem_busy = 1'b1;
                stall--;
            end else begin
                bus.mem_busy = 1'b0;
                if (exp_addr.size() == 0) check("mem_addr_extra_beat", 64'(1), 64'(0));
                else check("mem_addr", 64'(bus.mem_addr), 64'(exp_addr.pop_front()));
                check("mem_wren", 64'(bus.mem_wren), 64'(!v.is_fetch && v.wr));
                if (!v.is_fetch && v.wr) check("mem_wdata", 64'(bus.mem_wdata), 64'(v.wdata));
                issued++;
            end
            if (cyc == 1) check("gnt_pulse_width", 64'(bus.if_gnt | bus.dm_gnt), 64'(0));
            cyc++;
            guard++;
            @(negedge clk);
        end
        bus.mem_busy = 1'b0;
        check("issue_cycles", 64'(cyc), 64'(v.exp_cycles));
    endtask

    vec_t vecs [9];

    initial begin
        int          n, guard;
        byte         got_c;
        string       order;
        vec_t        post;

        vecs[0] = '{1'b1, 32'h8002_0000, 2'b00, 1'b0, 32'h0,         0, 0, 1};
        vecs[1] = '{1'b1, 32'h8002_0000, 2'b01, 1'b0, 32'h0,         1, 2, 6};
        vecs[2] = '{1'b0, 32'h8002_0010, 2'b00, 1'b1, 32'hDEAD_BEEF, 0, 0, 1};
        vecs[3] = '{1'b0, 32'h8002_0010, 2'b00, 1'b0, 32'h0,         0, 0, 1};
        vecs[4] = '{1'b1, 32'hFFFF_FFF8, 2'b01, 1'b0, 32'h0,         0, 0, 4};
        vecs[5] = '{1'b1, 32'h0000_1000, 2'b10, 1'b0, 32'h0,         0, 1, 9};
        vecs[6] = '{1'b1, 32'h0000_2000, 2'b11, 1'b0, 32'h0,         0, 0, 16};
        vecs[7] = '{1'b0, 32'h0000_2004, 2'b00, 1'b1, 32'h1234_5678, 0, 0, 1};
        vecs[8] = '{1'b1, 32'h0000_2000, 2'b01, 1'b0, 32'h0,         2, 3, 7};

        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_size = 2'b00;
        bus.dm_req = 1'b0; bus.dm_addr = '0; bus.dm_wr = 1'b0; bus.dm_wdata = '0;
        bus.mem_busy = 1'b0; bus.mem_rdata = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("reset_outputs",
              64'({bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.dm_done,
                   bus.mem_wren, bus.mem_enable, bus.mem_acc_size, bus.mem_addr}), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_request", 64'(bus.mem_enable), 64'(0));

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // Contention: both requesters held; grant order with forced fetch priority
        order = "DDDDFDDDDF";
        @(posedge clk); #1;
        bus.if_addr = 32'h0000_4000; bus.if_size = 2'b00;
        bus.dm_addr = 32'h0000_5000; bus.dm_wr = 1'b0;
        bus.if_req = 1'b1; bus.dm_req = 1'b1;
        n = 0; guard = 0;
        while (n < 10 && guard < 60) begin
            @(negedge clk);
            guard++;
            if (bus.if_gnt || bus.dm_gnt) begin
                got_c = bus.if_gnt ? "F" : "D";
                check("grant_order", 64'(got_c), 64'(order[n]));
                if (bus.if_gnt) exp_if.push_back(ref_word(32'h0000_4000));
                else exp_dm.push_back('{done: 1'b0, data: ref_word(32'h0000_5000)});
                n++;
                if (n == 10) begin
                    bus.if_req = 1'b0;
                    bus.dm_req = 1'b0;
                end
            end
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        check("contention_grants", 64'(n), 64'(10));
        check("contention_cycles", 64'(guard), 64'(20));
        repeat (3) @(negedge clk);

        // Reset during beat 2 of an 8-beat fetch
        @(posedge clk); #1;
        exp_if.push_back(ref_word(32'h0000_3000));
        exp_if.push_back(ref_word(32'h0000_3004));
        bus.if_addr = 32'h0000_3000; bus.if_size = 2'b10; bus.if_req = 1'b1;
        guard = 0;
        while (!bus.if_gnt && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        bus.if_req = 1'b0;
        check("rst_seq_gnt", 64'(bus.if_gnt), 64'(1));
        guard = 0;
        while (bus.mem_addr != 32'h0000_3008 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rst_seq_beat2_addr", 64'(bus.mem_addr), 64'(32'h0000_3008));
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_outputs",
              64'({bus.mem_enable, bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.mem_wren}), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_stale_enable", 64'(bus.mem_enable), 64'(0));

        post = '{1'b1, 32'h0000_6000, 2'b01, 1'b0, 32'h0, 0, 0, 4};
        run_txn(post);
        post = '{1'b0, 32'h8002_0010, 2'b00, 1'b0, 32'h0, 0, 0, 1};
        run_txn(post);

        repeat (4) @(negedge clk);
        check("if_queue_drained", 64'(exp_if.size()), 64'(0));
        check("dm_queue_drained", 64'(exp_dm.size()), 64'(0));
        check("addr_queue_drained", 64'(exp_addr.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single `mainMem` port between the instruction-fetch stage and the data-memory (load/store) stage of the MIPS pipeline. Accepts one request at a time, converts fetch bursts into consecutive single-word memory accesses, honours the memory `busy` stall, and routes read data or write completion back to the owner. Sits between `fetch` / Execute-stage memory logic and `mainMem`, replacing the bench-driven address mux.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 4, fetch losses to data before fetch gets forced priority (1..15)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request (read only)
- if_addr  in  ADDR_W  fetch start address
- if_size  in  2  burst: 00=1, 01=4, 10=8, 11=16 words
- if_gnt  out  1  one-cycle accept pulse
- if_rvalid  out  1  fetch read beat valid
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request (single word)
- dm_addr  in  ADDR_W  data address
- dm_wr  in  1  1=store, 0=load
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle accept pulse
- dm_rvalid  out  1  load data valid
- dm_rdata  out  DATA_W  load data
- dm_done  out  1  store completed pulse
- mem_addr  out  ADDR_W  to mainMem addr
- mem_wdata  out  DATA_W  to mainMem data_in
- mem_wren  out  1  to mainMem wren
- mem_acc_size  out  2  constant 00
- mem_enable  out  1  to mainMem enable
- mem_busy  in  1  mainMem busy
- mem_rdata  in  DATA_W  mainMem data_out

## Operation
- States: IDLE, ISSUE. Reset → IDLE; all outputs 0, beat counter 0, wait counter 0, owner = none, in-flight rvalid discarded.
- IDLE: requests sampled on each edge. Decision: if wait counter == MAX_WAIT and if_req → fetch; else dm_req → data; else if_req → fetch; else stay. On grant: latch addr, beat count (data always 1; fetch per if_size), dm_wr/dm_wdata; go ISSUE.
- Wait counter: +1 on each decision where data wins while if_req=1; cleared when fetch granted; saturates at MAX_WAIT.
- ISSUE: mem_enable=1, mem_addr = current beat address, mem_wren = latched dm_wr (0 for fetch), mem_wdata = latched wdata. A beat is issued on an edge with mem_enable=1 and mem_busy=0; then address += 4 (mod 2^ADDR_W, wraps) and beat count −1. Busy=1: address, count, outputs held. After last beat issued → IDLE (mem_enable=0).
- Requests are ignored while in ISSUE; a requester still asserting req when back in IDLE is a new request. Requesters must drop req the cycle after gnt.
- Read return: for a read beat issued at edge E, owner's rvalid=1 and rdata=mem_rdata during the cycle after E. Store: dm_done=1 during the cycle after its issue edge. Return path is independent of state, so the last beat's rvalid overlaps IDLE.
- Addresses passed unaligned-unchecked; only +4 increments applied.

## Timing
- Req seen at edge E0 (IDLE) → gnt pulse, mem_enable=1, beat 0 address in cycle E0..E1.
- No busy: beat k issued at E(k+1); rvalid in cycle after; N-beat burst occupies N cycles of ISSUE.
- Back-to-back: one IDLE cycle between transactions; minimum single-word period 2 cycles.
- Busy inserts one-cycle stall per busy cycle, no beat lost or duplicated.
- reset_n asserted mid-burst: outputs to 0 asynchronously; no further rvalid/done for that transaction.
- Simultaneous if_req and dm_req: data wins unless wait counter == MAX_WAIT.

## Test plan
- Fetch single: if_req, if_addr=0x80020000, size 00 → if_gnt next cycle, mem_addr=0x80020000, one if_rvalid with memory word, back to IDLE.
- Fetch burst 4 from 0x80020000 with mem_busy high 2 cycles after beat 1 → mem_addr 0x…00,04,08,0C, exactly 4 if_rvalid, ISSUE lasts 6 cycles.
- Store then load: dm_wr=1 addr 0x80020010 data 0xDEADBEEF → dm_done; then load same addr → dm_rvalid with 0xDEADBEEF.
- Contention: both req held continuously, MAX_WAIT=4 → grant order D,D,D,D,F,D,…; counter cleared after F.
- Wrap: fetch burst 4 at 0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- reset_n low during beat 2 of 8-beat burst → mem_enable, gnt, rvalid 0 immediately; after release, IDLE accepts a new request normally.
